// File: rtl/bowling_round_sequencer.sv
// Game-level sequencer: turns pin-FSM hit/miss pulses into round count, score and phase,
// and pulses round/game resets back to the aim, power and pin blocks.
`timescale 1ns/1ps
module bowling_round_sequencer #(
  parameter int NUM_ROUNDS     = 10,
  parameter int SCORE_W        = 5,
  parameter int SETTLE_CYCLES  = 25000000,
  parameter int TIMEOUT_CYCLES = 250000000
) (
  input  logic               CLOCK_50,
  input  logic               reset,
  input  logic               start,
  input  logic               throw,
  input  logic               hit,
  input  logic               miss,
  output logic               round_reset,
  output logic               game_reset,
  output logic [3:0]         round_num,
  output logic [SCORE_W-1:0] score,
  output logic [1:0]         phase,
  output logic               game_over,
  output logic               proto_err
);

  localparam int SW = (SETTLE_CYCLES  > 1) ? $clog2(SETTLE_CYCLES)  : 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_AIMPOWER, S_CALCULATE, S_SETTLE, S_UPDATE, S_OVER
  } state_e;

  state_e             state_q, state_d;
  logic [3:0]         round_q, round_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic               err_q, err_d;
  logic [SW-1:0]      settle_q, settle_d;
  logic [TW-1:0]      tmo_q, tmo_d;
  logic               round_reset_q, round_reset_d;
  logic               game_reset_q, game_reset_d;
  logic [1:0]         phase_q, phase_d;
  logic               game_over_q, game_over_d;

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      round_q       <= '0;
      score_q       <= '0;
      err_q         <= 1'b0;
      settle_q      <= '0;
      tmo_q         <= '0;
      round_reset_q <= 1'b0;
      game_reset_q  <= 1'b0;
      phase_q       <= 2'b11;
      game_over_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      round_q       <= round_d;
      score_q       <= score_d;
      err_q         <= err_d;
      settle_q      <= settle_d;
      tmo_q         <= tmo_d;
      round_reset_q <= round_reset_d;
      game_reset_q  <= game_reset_d;
      phase_q       <= phase_d;
      game_over_q   <= game_over_d;
    end
  end

  // Phase and game_over are derived from the next state so they register alongside it.
  always_comb begin
    state_d       = state_q;
    round_d       = round_q;
    score_d       = score_q;
    err_d         = err_q;
    settle_d      = settle_q;
    tmo_d         = tmo_q;
    round_reset_d = 1'b0;
    game_reset_d  = 1'b0;

    unique case (state_q)
      S_IDLE, S_OVER: begin
        if (start) begin
          state_d      = S_AIMPOWER;
          score_d      = '0;
          round_d      = 4'd1;
          err_d        = 1'b0;
          game_reset_d = 1'b1;
        end
      end
      S_AIMPOWER: begin
        if (throw) begin
          state_d = S_CALCULATE;
          tmo_d   = '0;
        end
      end
      S_CALCULATE: begin
        if (hit || miss) begin
          if (hit && !miss && (score_q != {SCORE_W{1'b1}})) score_d = score_q + 1'b1;
          if (hit && miss) err_d = 1'b1;
          state_d  = S_SETTLE;
          settle_d = SW'(SETTLE_CYCLES - 1);
        end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
          err_d    = 1'b1;
          state_d  = S_SETTLE;
          settle_d = SW'(SETTLE_CYCLES - 1);
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_SETTLE: begin
        if (settle_q == '0) state_d = S_UPDATE;
        else                settle_d = settle_q - 1'b1;
      end
      S_UPDATE: begin
        if (round_q == 4'(NUM_ROUNDS)) begin
          state_d = S_OVER;
        end else begin
          round_d       = round_q + 1'b1;
          state_d       = S_AIMPOWER;
          round_reset_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    unique case (state_d)
      S_AIMPOWER:            phase_d = 2'b00;
      S_CALCULATE, S_SETTLE: phase_d = 2'b01;
      S_UPDATE:              phase_d = 2'b10;
      default:               phase_d = 2'b11;
    endcase
    game_over_d = (state_d == S_OVER);
  end

  assign round_reset = round_reset_q;
  assign game_reset  = game_reset_q;
  assign round_num   = round_q;
  assign score       = score_q;
  assign phase       = phase_q;
  assign game_over   = game_over_q;
  assign proto_err   = err_q;

endmodule
